// File: rtl/pkg_1553.sv
// Constants shared by the 1553 encoder and decoder, plus the word-pattern builder.
package pkg_1553;

    localparam logic TUSER_CMD_STAT = 1'b1;
    localparam logic TUSER_DATA     = 1'b0;

    localparam logic [1:0] LVL_POS  = 2'b01;
    localparam logic [1:0] LVL_NEG  = 2'b10;
    localparam logic [1:0] LVL_IDLE = 2'b00;

    localparam int unsigned WORD_HALVES = 40;
    localparam int unsigned SYNC_HALVES = 6;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // One bit per half-bit, MSB is sent first; 1 = positive level, 0 = negative level.
    function automatic logic [WORD_HALVES-1:0] build_pattern(
        input logic [15:0] data,
        input logic        sync_type,
        input logic        invert_parity
    );
        logic [WORD_HALVES-1:0] pat;
        logic                   par;
        pat = '0;
        pat[WORD_HALVES-1 -: SYNC_HALVES] = (sync_type == TUSER_CMD_STAT) ? 6'b111000 : 6'b000111;
        for (int unsigned i = 0; i < 16; i++) begin
            pat[WORD_HALVES-1-SYNC_HALVES-2*i] = data[15-i];
            pat[WORD_HALVES-2-SYNC_HALVES-2*i] = ~data[15-i];
        end
        par    = (~^data) ^ invert_parity;
        pat[1] = par;
        pat[0] = ~par;
        return pat;
    endfunction

    function automatic logic [1:0] half_level(input logic positive);
        return positive ? LVL_POS : LVL_NEG;
    endfunction

endpackage

// File: rtl/manchester_half_timer.sv
// Half-bit timer: counts HALF cycles per half-bit and HALVES half-bits per word.
module manchester_half_timer #(
    parameter int unsigned HALF   = 50,
    parameter int unsigned HALVES = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic half_tick,
    output logic pre_tick,
    output logic last_half
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned IW = (HALVES > 1) ? $clog2(HALVES) : 1;

    logic [CW-1:0] count;
    logic [IW-1:0] index;

    assign half_tick = enable && (count == CW'(HALF - 1));
    // Asserted one cycle before half_tick so a registered consumer lines up with it.
    assign pre_tick  = enable && (count == CW'(HALF - 2));
    assign last_half = (index == IW'(HALVES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            index <= '0;
        end else if (enable) begin
            if (count == CW'(HALF - 1)) begin
                count <= '0;
                index <= last_half ? '0 : index + 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_1553_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II word serialiser driving a differential pair.
module axis_1553_encoder
    import pkg_1553::*;
#(
    parameter int unsigned clock_speed = 100000000,
    parameter int unsigned bit_rate    = 1000000
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [15:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [1:0]  diff,
    output logic        busy
);

    localparam int unsigned HALF = clock_speed / (2 * bit_rate);

    state_t                 state;
    logic [WORD_HALVES-1:0] pattern;
    logic [WORD_HALVES-1:0] next_pattern;
    logic                   accept;
    logic                   half_tick;
    logic                   pre_tick;
    logic                   last_half;
    logic                   unused_tuser;

    assign accept       = s_axis_tvalid && s_axis_tready;
    assign next_pattern = build_pattern(s_axis_tdata, s_axis_tuser[0], s_axis_tuser[1]);
    assign unused_tuser = ^s_axis_tuser[7:2];

    manchester_half_timer #(
        .HALF   (HALF),
        .HALVES (WORD_HALVES)
    ) u_timer (
        .clk       (aclk),
        .rst       (arst),
        .clear     (state == IDLE),
        .enable    (state == SEND),
        .half_tick (half_tick),
        .pre_tick  (pre_tick),
        .last_half (last_half)
    );

    always_ff @(posedge aclk) begin
        if (arst) begin
            state         <= IDLE;
            pattern       <= '0;
            diff          <= LVL_IDLE;
            busy          <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_axis_tready <= 1'b1;
                    diff          <= LVL_IDLE;
                    busy          <= 1'b0;
                    if (accept) begin
                        state         <= SEND;
                        pattern       <= next_pattern;
                        diff          <= half_level(next_pattern[WORD_HALVES-1]);
                        busy          <= 1'b1;
                        s_axis_tready <= 1'b0;
                    end
                end
                SEND: begin
                    // tready is registered, so raise it one cycle early to cover the final cycle.
                    s_axis_tready <= pre_tick && last_half;
                    if (half_tick) begin
                        if (last_half) begin
                            if (accept) begin
                                pattern       <= next_pattern;
                                diff          <= half_level(next_pattern[WORD_HALVES-1]);
                                s_axis_tready <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                diff          <= LVL_IDLE;
                                busy          <= 1'b0;
                                s_axis_tready <= 1'b1;
                            end
                        end else begin
                            pattern <= pattern << 1;
                            diff    <= half_level(pattern[WORD_HALVES-2]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_1553_encoder.sv
// Self-checking bench for axis_1553_encoder against a rule-based per-cycle line model.
module tb_axis_1553_encoder;

    localparam int HALF = 50;
    localparam int WORD = 40 * HALF;

    logic        aclk   = 1'b0;
    logic        arst   = 1'b1;
    logic [15:0] tdata  = '0;
    logic [7:0]  tuser  = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [1:0]  diff;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] words [8];
    logic [7:0]  users [8];

    axis_1553_encoder #(
        .clock_speed (100000000),
        .bit_rate    (1000000)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .s_axis_tdata  (tdata),
        .s_axis_tuser  (tuser),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .diff          (diff),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    // Expected line level t cycles into a word, from the word-format rules.
    function automatic logic [1:0] exp_level(input logic [15:0] d, input logic [7:0] u, input int t);
        int   h;
        logic pos;
        logic b;
        h = t / HALF;
        if (h < 3) begin
            pos = u[0];
        end else if (h < 6) begin
            pos = !u[0];
        end else if (h < 38) begin
            b   = d[15 - (h - 6) / 2];
            pos = ((h - 6) % 2 == 0) ? b : !b;
        end else begin
            b   = (^d) ^ 1'b1 ^ u[1];
            pos = (h == 38) ? b : !b;
        end
        return pos ? 2'b01 : 2'b10;
    endfunction

    task automatic run_stream(input int n, input string name);
        int         waited;
        int         bad_d, bad_b, bad_r, first_t;
        logic [1:0] first_v, first_e, e;
        int         w, t;
        tdata  = words[0];
        tuser  = users[0];
        tvalid = 1'b1;
        waited = 0;
        while (tready !== 1'b1 && waited < 20) begin
            @(posedge aclk); #1;
            waited++;
        end
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_wait: tready=%b required 1", name, tready);
            tvalid = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        bad_d = 0; bad_b = 0; bad_r = 0; first_t = -1; first_v = '0; first_e = '0;
        for (int k = 0; k < n * WORD; k++) begin
            w = k / WORD;
            t = k % WORD;
            e = exp_level(words[w], users[w], t);
            if (diff !== e) begin
                if (bad_d == 0) begin
                    first_t = t; first_v = diff; first_e = e;
                end
                bad_d++;
            end
            if (busy !== 1'b1) bad_b++;
            if (tready !== logic'(t == WORD - 1)) bad_r++;
            if (t == WORD - 1) begin
                checks++;
                if (bad_d != 0) begin
                    errors++;
                    $display("FAIL %s_diff word %0d: %0d bad cycles, first at cycle %0d got %b required %b",
                             name, w, bad_d, first_t, first_v, first_e);
                end
                checks++;
                if (bad_b != 0) begin
                    errors++;
                    $display("FAIL %s_busy word %0d: %0d cycles with busy!=1, required 0", name, w, bad_b);
                end
                checks++;
                if (bad_r != 0) begin
                    errors++;
                    $display("FAIL %s_tready word %0d: %0d cycles wrong, required 0", name, w, bad_r);
                end
                bad_d = 0; bad_b = 0; bad_r = 0;
                tvalid = (w + 1 < n);
                if (w + 1 < n) begin
                    tdata = words[w+1];
                    tuser = users[w+1];
                end
            end else begin
                tdata  = 16'($urandom);
                tuser  = 8'($urandom);
                tvalid = 1'($urandom_range(0, 1));
            end
            @(posedge aclk); #1;
        end
        checks++;
        if (diff !== 2'b00 || busy !== 1'b0 || tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_gap: diff=%b busy=%b tready=%b required diff=00 busy=0 tready=1",
                     name, diff, busy, tready);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; tvalid = 1'b0;
        @(posedge aclk); @(posedge aclk); #1;
        checks++;
        if (diff !== 2'b00 || busy !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: diff=%b busy=%b tready=%b required 00/0/0", diff, busy, tready);
        end
        arst = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (tready !== 1'b1 || diff !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: tready=%b diff=%b busy=%b required 1/00/0", tready, diff, busy);
        end
    endtask

    task automatic test_idle_hold();
        int bad;
        bad = 0;
        tvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tdata = 16'($urandom); tuser = 8'($urandom);
            @(posedge aclk); #1;
            if (diff !== 2'b00 || busy !== 1'b0 || tready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold: %0d bad idle cycles, required 0", bad);
        end
    endtask

    task automatic test_directed();
        words[0] = 16'h0000; users[0] = 8'h01; run_stream(1, "cmd_zero");
        words[0] = 16'hFFFF; users[0] = 8'h00; run_stream(1, "data_ones");
        words[0] = 16'h0001; users[0] = 8'h03; run_stream(1, "parity_inv");
    endtask

    task automatic test_back_to_back();
        words[0] = 16'hA5A5; users[0] = 8'h01;
        words[1] = 16'h5A5A; users[1] = 8'h00;
        run_stream(2, "b2b");
    endtask

    task automatic test_mid_reset();
        int bad;
        words[0] = 16'($urandom); users[0] = 8'($urandom);
        tdata = words[0]; tuser = users[0]; tvalid = 1'b1;
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: tready=%b required 1", tready);
        end
        @(posedge aclk); #1;
        tvalid = 1'b0;
        bad = 0;
        for (int k = 0; k < 700; k++) begin
            if (diff !== exp_level(words[0], users[0], k)) bad++;
            @(posedge aclk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_prefix: %0d bad cycles, required 0", bad);
        end
        arst = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (diff !== 2'b00 || busy !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: diff=%b busy=%b tready=%b required 00/0/0", diff, busy, tready);
        end
        arst = 1'b0;
        @(posedge aclk); #1;
        words[0] = 16'($urandom); users[0] = 8'($urandom);
        run_stream(1, "after_reset");
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                words[i] = 16'($urandom);
                users[i] = 8'($urandom);
            end
            run_stream(n, "random");
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(posedge aclk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
